// File: rtl/sap_acc_datapath_if.sv
// rtl/sap_acc_datapath_if.sv - strobe/bus bundle between the SAP sequencer side and the accumulator datapath
// Optional ALU_PARITY_EN adds the registered alu_p result-parity output.
interface sap_acc_datapath_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       opcode;
  logic [WIDTH-1:0] ram_to_a;
  logic [WIDTH-1:0] ram_to_b;
  logic [WIDTH-1:0] tmp_to_b;
  logic [WIDTH-1:0] tmp_to_alu;
  logic             carry_in;
  logic             LaRam, Lab, LaALU;
  logic             Eatmp, EaRAM, EaOut, EaCarry;
  logic             Lbtmp, LbALU, Lcarry, Lpop;
  logic             Eba, Epush, Ercl;
  logic             Eu;
  logic [WIDTH-1:0] a_to_tmp;
  logic [WIDTH-1:0] a_to_ram;
  logic [WIDTH-1:0] a_to_out;
  logic [WIDTH-1:0] b_to_ram;
  logic             carry_from_a;
  logic             carry_from_b;
  logic             alu_z;
  logic             alu_c;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
`ifdef ALU_PARITY_EN
  logic             alu_p;
`endif

  modport master (
`ifdef ALU_PARITY_EN
    input  alu_p,
`endif
    output opcode, ram_to_a, ram_to_b, tmp_to_b, tmp_to_alu, carry_in,
    output LaRam, Lab, LaALU, Eatmp, EaRAM, EaOut, EaCarry,
    output Lbtmp, LbALU, Lcarry, Lpop, Eba, Epush, Ercl, Eu,
    input  a_to_tmp, a_to_ram, a_to_out, b_to_ram, carry_from_a, carry_from_b,
    input  alu_z, alu_c, a_q, b_q
  );

  modport slave (
`ifdef ALU_PARITY_EN
    output alu_p,
`endif
    input  opcode, ram_to_a, ram_to_b, tmp_to_b, tmp_to_alu, carry_in,
    input  LaRam, Lab, LaALU, Eatmp, EaRAM, EaOut, EaCarry,
    input  Lbtmp, LbALU, Lcarry, Lpop, Eba, Epush, Ercl, Eu,
    output a_to_tmp, a_to_ram, a_to_out, b_to_ram, carry_from_a, carry_from_b,
    output alu_z, alu_c, a_q, b_q
  );
endinterface

// File: rtl/sap_acc_datapath.sv
// rtl/sap_acc_datapath.sv - SAP accumulator slice: A/B registers, ALU with registered result and flags
// Optional ALU_PARITY_EN registers even parity of the ALU result on Eu as alu_p.
module sap_acc_datapath #(
  parameter int WIDTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  sap_acc_datapath_if.slave   bus
);
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             z_reg, c_reg, cfb_reg;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  logic [WIDTH-1:0] a_next, b_next;

  // Subtractions keep the borrow in the extra top bit of the zero-extended difference.
  always_comb begin
    sum = {1'b0, a_reg};
    case (bus.opcode)
      4'b0001: sum = {1'b0, a_reg} + {1'b0, b_reg};
      4'b0010: sum = {1'b0, a_reg} - {1'b0, b_reg};
      4'b0100: sum = {1'b0, a_reg & b_reg};
      4'b0101: sum = {1'b0, a_reg | b_reg};
      4'b0110: sum = {1'b0, a_reg ^ b_reg};
      4'b1000: sum = {1'b0, a_reg} + {1'b0, bus.tmp_to_alu};
      4'b1001: sum = {1'b0, a_reg} - {1'b0, bus.tmp_to_alu};
      4'b1010: sum = {1'b0, a_reg} + (WIDTH+1)'(1);
      4'b1011: sum = {1'b0, a_reg} - (WIDTH+1)'(1);
      4'b1110: sum = {1'b0, ~a_reg};
      default: sum = {1'b0, a_reg};
    endcase
    alu_res = sum[WIDTH-1:0];
    alu_cy  = sum[WIDTH];
  end

  // Lab without Eba loads 0, which lets the XCHG sequence reuse the gated B path.
  always_comb begin
    a_next = a_reg;
    if (bus.LaRam)      a_next = bus.ram_to_a;
    else if (bus.Lab)   a_next = bus.Eba ? b_reg : '0;
    else if (bus.LaALU) a_next = res_reg;
  end

  always_comb begin
    b_next = b_reg;
    if (bus.Lpop)        b_next = bus.ram_to_b;
    else if (bus.Lbtmp)  b_next = bus.tmp_to_b;
    else if (bus.LbALU)  b_next = res_reg;
    else if (bus.Lcarry) b_next = {{(WIDTH-1){1'b0}}, bus.carry_in};
    else if (bus.Ercl)   b_next = {b_reg[WIDTH-2:0], bus.carry_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
      z_reg   <= 1'b0;
      c_reg   <= 1'b0;
      cfb_reg <= 1'b0;
    end else begin
      a_reg <= a_next;
      b_reg <= b_next;
      if (bus.Ercl && !(bus.Lpop || bus.Lbtmp || bus.LbALU || bus.Lcarry))
        cfb_reg <= b_reg[WIDTH-1];
      if (bus.Eu) begin
        res_reg <= alu_res;
        z_reg   <= (alu_res == '0);
        c_reg   <= alu_cy;
      end
    end
  end

`ifdef ALU_PARITY_EN
  logic p_reg;
  always_ff @(posedge clk) begin
    if (reset)       p_reg <= 1'b0;
    else if (bus.Eu) p_reg <= ^alu_res;
  end
  assign bus.alu_p = p_reg;
`endif

  assign bus.a_to_tmp     = bus.Eatmp ? a_reg : '0;
  assign bus.a_to_ram     = bus.EaRAM ? a_reg : '0;
  assign bus.a_to_out     = bus.EaOut ? a_reg : '0;
  assign bus.b_to_ram     = bus.Epush ? b_reg : '0;
  assign bus.carry_from_a = bus.EaCarry ? a_reg[WIDTH-1] : 1'b0;
  assign bus.carry_from_b = cfb_reg;
  assign bus.alu_z        = z_reg;
  assign bus.alu_c        = c_reg;
  assign bus.a_q          = a_reg;
  assign bus.b_q          = b_reg;
endmodule

// File: tb/tb_sap_acc_datapath.sv
// tb/tb_sap_acc_datapath.sv - directed plus randomized checks of sap_acc_datapath against an arithmetic model
// Parity output is checked when ALU_PARITY_EN is defined.
module tb_sap_acc_datapath;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  int   m_a, m_b, m_res, m_z, m_c, m_cfb, m_p;

  always #5 clk = ~clk;

  sap_acc_datapath_if #(.WIDTH(4)) bus ();
  sap_acc_datapath #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_inputs();
    bus.opcode = 4'h0; bus.ram_to_a = '0; bus.ram_to_b = '0; bus.tmp_to_b = '0;
    bus.tmp_to_alu = '0; bus.carry_in = 1'b0;
    bus.LaRam = 0; bus.Lab = 0; bus.LaALU = 0;
    bus.Eatmp = 0; bus.EaRAM = 0; bus.EaOut = 0; bus.EaCarry = 0;
    bus.Lbtmp = 0; bus.LbALU = 0; bus.Lcarry = 0; bus.Lpop = 0;
    bus.Eba = 0; bus.Epush = 0; bus.Ercl = 0; bus.Eu = 0;
    reset = 1'b0;
  endtask

  // Arithmetic reference: result is mod 16, carry means overflow above 15 or a negative difference.
  task automatic alu_model(input int op, input int a, input int b, input int t,
                           output int res, output int c);
    int v;
    case (op)
      1:  v = a + b;
      2:  v = a - b;
      4:  v = a & b;
      5:  v = a | b;
      6:  v = a ^ b;
      8:  v = a + t;
      9:  v = a - t;
      10: v = a + 1;
      11: v = a - 1;
      14: v = 15 - a;
      default: v = a;
    endcase
    c   = (v > 15 || v < 0) ? 1 : 0;
    res = (v + 16) % 16;
  endtask

  task automatic check_all();
    chk("a_q", bus.a_q, m_a);
    chk("b_q", bus.b_q, m_b);
    chk("alu_z", bus.alu_z, m_z);
    chk("alu_c", bus.alu_c, m_c);
    chk("carry_from_b", bus.carry_from_b, m_cfb);
    chk("a_to_tmp", bus.a_to_tmp, bus.Eatmp ? m_a : 0);
    chk("a_to_ram", bus.a_to_ram, bus.EaRAM ? m_a : 0);
    chk("a_to_out", bus.a_to_out, bus.EaOut ? m_a : 0);
    chk("b_to_ram", bus.b_to_ram, bus.Epush ? m_b : 0);
    chk("carry_from_a", bus.carry_from_a, bus.EaCarry ? (m_a / 8) : 0);
`ifdef ALU_PARITY_EN
    chk("alu_p", bus.alu_p, m_p);
`endif
  endtask

  // Applies the inputs currently driven for one clock edge, advancing the model alongside.
  task automatic cycle();
    int na, nb, r, c, ones;
    if (reset) begin
      na = 0; nb = 0; m_res = 0; m_z = 0; m_c = 0; m_cfb = 0; m_p = 0;
    end else begin
      alu_model(int'(bus.opcode), m_a, m_b, int'(bus.tmp_to_alu), r, c);
      na = m_a;
      if (bus.LaRam)      na = int'(bus.ram_to_a);
      else if (bus.Lab)   na = bus.Eba ? m_b : 0;
      else if (bus.LaALU) na = m_res;
      nb = m_b;
      if (bus.Lpop)        nb = int'(bus.ram_to_b);
      else if (bus.Lbtmp)  nb = int'(bus.tmp_to_b);
      else if (bus.LbALU)  nb = m_res;
      else if (bus.Lcarry) nb = int'(bus.carry_in);
      else if (bus.Ercl) begin
        nb    = (m_b * 2) % 16 + int'(bus.carry_in);
        m_cfb = m_b / 8;
      end
      if (bus.Eu) begin
        m_res = r;
        m_z   = (r == 0) ? 1 : 0;
        m_c   = c;
        ones  = 0;
        for (int i = 0; i < 4; i++) ones += (r >> i) & 1;
        m_p   = ones % 2;
      end
    end
    m_a = na;
    m_b = nb;
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    m_a = 0; m_b = 0; m_res = 0; m_z = 0; m_c = 0; m_cfb = 0; m_p = 0;
    clear_inputs();
    reset = 1'b1;
    cycle();
    cycle();

    // A=B=5 then a one-cycle reset
    clear_inputs(); bus.LaRam = 1; bus.ram_to_a = 4'd5; bus.Lpop = 1; bus.ram_to_b = 4'd5; cycle();
    clear_inputs(); bus.opcode = 4'b0001; bus.Eu = 1; cycle();
    clear_inputs(); reset = 1'b1; bus.Eatmp = 1; bus.EaRAM = 1; bus.EaOut = 1; bus.Epush = 1; cycle();
    chk("reset_a", bus.a_q, 0);
    chk("reset_b", bus.b_q, 0);
    chk("reset_bus", {bus.a_to_tmp, bus.a_to_ram, bus.a_to_out, bus.b_to_ram}, 0);

    // XCHG A,B
    clear_inputs(); bus.LaRam = 1; bus.ram_to_a = 4'b1010; bus.Lpop = 1; bus.ram_to_b = 4'b1011; cycle();
    clear_inputs(); bus.Eatmp = 1; cycle();
    chk("xchg_tmp", bus.a_to_tmp, 4'b1010);
    clear_inputs(); bus.Lab = 1; bus.Eba = 1; cycle();
    clear_inputs(); bus.Lbtmp = 1; bus.tmp_to_b = 4'b1010; cycle();
    chk("xchg_a", bus.a_q, 4'b1011);
    chk("xchg_b", bus.b_q, 4'b1010);

    // 1111 + 0001 wraps to 0 with carry
    clear_inputs(); bus.LaRam = 1; bus.ram_to_a = 4'hF; bus.Lpop = 1; bus.ram_to_b = 4'h1; cycle();
    clear_inputs(); bus.opcode = 4'b0001; bus.Eu = 1; cycle();
    clear_inputs(); bus.LaALU = 1; cycle();
    chk("add_wrap_a", bus.a_q, 0);
    chk("add_wrap_zc", {bus.alu_z, bus.alu_c}, 2'b11);

    // 0000 - 0001 borrows into B
    clear_inputs(); bus.LaRam = 1; bus.ram_to_a = 4'h0; bus.Lpop = 1; bus.ram_to_b = 4'h1; cycle();
    clear_inputs(); bus.opcode = 4'b0010; bus.Eu = 1; cycle();
    clear_inputs(); bus.LbALU = 1; cycle();
    chk("sub_borrow_b", bus.b_q, 4'hF);
    chk("sub_borrow_zc", {bus.alu_z, bus.alu_c}, 2'b01);
    chk("sub_borrow_a", bus.a_q, 0);

    // Push/pop through the RAM bus
    clear_inputs(); bus.Lpop = 1; bus.ram_to_b = 4'b1001; cycle();
    clear_inputs(); bus.Epush = 1; cycle();
    chk("push", bus.b_to_ram, 4'b1001);
    clear_inputs(); bus.Lpop = 1; bus.ram_to_b = 4'b0110; cycle();
    chk("pop_b", bus.b_q, 4'b0110);
    chk("push_low", bus.b_to_ram, 0);

    // Rotate through carry, then LaRam beats Lab
    clear_inputs(); bus.Lpop = 1; bus.ram_to_b = 4'b1000; cycle();
    clear_inputs(); bus.carry_in = 1; bus.Ercl = 1; cycle();
    chk("rcl_b", bus.b_q, 4'b0001);
    chk("rcl_cfb", bus.carry_from_b, 1);
    clear_inputs(); bus.LaRam = 1; bus.Lab = 1; bus.Eba = 1; bus.ram_to_a = 4'b0011; cycle();
    chk("prio_a", bus.a_q, 4'b0011);

    // Eu with LaALU on the same edge: A receives the older result
    clear_inputs(); bus.opcode = 4'b1010; bus.Eu = 1; cycle();
    clear_inputs(); bus.opcode = 4'b1110; bus.Eu = 1; bus.LaALU = 1; cycle();
    chk("eu_laalu_a", bus.a_q, 4'b0100);
    clear_inputs(); bus.LaALU = 1; cycle();
    chk("eu_laalu_next", bus.a_q, 4'b1100);

    // Reset between Eu and the result load discards the pending result
    clear_inputs(); bus.opcode = 4'b1110; bus.Eu = 1; cycle();
    clear_inputs(); reset = 1'b1; cycle();
    clear_inputs(); bus.LaALU = 1; cycle();
    chk("reset_discard", bus.a_q, 0);

    for (int n = 0; n < 400; n++) begin
      clear_inputs();
      bus.opcode     = 4'($urandom);
      bus.ram_to_a   = 4'($urandom);
      bus.ram_to_b   = 4'($urandom);
      bus.tmp_to_b   = 4'($urandom);
      bus.tmp_to_alu = 4'($urandom);
      bus.carry_in   = 1'($urandom);
      bus.LaRam   = ($urandom_range(0, 5) == 0);
      bus.Lab     = ($urandom_range(0, 5) == 0);
      bus.LaALU   = ($urandom_range(0, 3) == 0);
      bus.Eatmp   = 1'($urandom);
      bus.EaRAM   = 1'($urandom);
      bus.EaOut   = 1'($urandom);
      bus.EaCarry = 1'($urandom);
      bus.Lbtmp   = ($urandom_range(0, 6) == 0);
      bus.LbALU   = ($urandom_range(0, 5) == 0);
      bus.Lcarry  = ($urandom_range(0, 6) == 0);
      bus.Lpop    = ($urandom_range(0, 6) == 0);
      bus.Eba     = 1'($urandom);
      bus.Epush   = 1'($urandom);
      bus.Ercl    = ($urandom_range(0, 2) == 0);
      bus.Eu      = 1'($urandom);
      reset       = ($urandom_range(0, 40) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
